// File: rtl/nes_pad_reader.sv
// NES controller poller: drives the 4021 latch/clock pins, samples the serial
// line through a two-flop synchroniser and publishes whole 8-button frames.
module nes_pad_reader #(
  parameter int LATCH_CYC = 1200,
  parameter int HALF_CYC  = 600,
  parameter int POLL_CYC  = 1_666_667
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic       data_in,
  output logic       latch_o,
  output logic       pulse_o,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       changed,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    WAIT  = 3'd2,
    PHI   = 3'd3,
    PLO   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int MAX_CYC = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] LATCH_LAST = TMR_W'(LATCH_CYC - 1);
  localparam logic [TMR_W-1:0] HALF_LAST  = TMR_W'(HALF_CYC - 1);

  state_t           state_r, state_s;
  logic [TMR_W-1:0] timer_r, timer_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       shift_r, shift_s, sample_s, buttons_s;
  logic [1:0]       dsync_r;
  logic             pending_r, pending_s, start_s, poll_tick_s, valid_s, changed_s;

  // Two-flop synchroniser; idles high like an undriven pad line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dsync_r <= 2'b11;
    end else begin
      dsync_r <= {dsync_r[0], data_in};
    end
  end

  generate
    if (POLL_CYC > 0) begin : g_poll
      localparam int POLL_W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
      logic [POLL_W-1:0] poll_cnt_r;
      logic              poll_tick_r;

      // Free-running poll divider; the tick is registered on the wrap
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          poll_cnt_r  <= '0;
          poll_tick_r <= 1'b0;
        end else if (poll_cnt_r == POLL_W'(POLL_CYC - 1)) begin
          poll_cnt_r  <= '0;
          poll_tick_r <= 1'b1;
        end else begin
          poll_cnt_r  <= poll_cnt_r + POLL_W'(1);
          poll_tick_r <= 1'b0;
        end
      end
      assign poll_tick_s = poll_tick_r;
    end else begin : g_no_poll
      assign poll_tick_s = 1'b0;
    end
  endgenerate

  // Next-state, frame datapath and output decode
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r + TMR_W'(1);
    idx_s     = idx_r;
    shift_s   = shift_r;
    pending_s = pending_r;
    buttons_s = buttons;
    valid_s   = 1'b0;
    changed_s = 1'b0;
    start_s   = trigger | poll_tick_s | pending_r;
    // First sampled bit ends up in bit 0 after eight right shifts
    sample_s  = {~dsync_r[1], shift_r[7:1]};

    if ((state_r != IDLE) && (trigger || poll_tick_s)) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end

    case (state_r)
      IDLE: begin
        timer_s = '0;
        if (start_s) begin
          state_s   = LATCH;
          pending_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      LATCH: begin
        if (timer_r == LATCH_LAST) begin
          state_s = WAIT;
          timer_s = '0;
        end else begin
          state_s = LATCH;
        end
      end
      WAIT: begin
        if (timer_r == HALF_LAST) begin
          state_s = PHI;
          timer_s = '0;
          shift_s = sample_s;
          idx_s   = 3'd1;
        end else begin
          state_s = WAIT;
        end
      end
      PHI: begin
        if (timer_r == HALF_LAST) begin
          state_s = PLO;
          timer_s = '0;
        end else begin
          state_s = PHI;
        end
      end
      PLO: begin
        if (timer_r == HALF_LAST) begin
          timer_s = '0;
          shift_s = sample_s;
          if (idx_r == 3'd7) begin
            state_s   = DONE;
            buttons_s = sample_s;
            valid_s   = 1'b1;
            changed_s = (sample_s != buttons);
          end else begin
            state_s = PHI;
            idx_s   = idx_r + 3'd1;
          end
        end else begin
          state_s = PLO;
        end
      end
      DONE: begin
        state_s = IDLE;
        timer_s = '0;
      end
      default: begin
        state_s = IDLE;
        timer_s = '0;
      end
    endcase
  end

  // State register; outputs decode from next state so they are registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      pending_r <= 1'b0;
      buttons   <= 8'h00;
      valid     <= 1'b0;
      changed   <= 1'b0;
      latch_o   <= 1'b0;
      pulse_o   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      idx_r     <= idx_s;
      shift_r   <= shift_s;
      pending_r <= pending_s;
      buttons   <= buttons_s;
      valid     <= valid_s;
      changed   <= changed_s;
      latch_o   <= (state_s == LATCH);
      pulse_o   <= (state_s == PHI);
      busy      <= (state_s != IDLE);
    end
  end

endmodule
